// File: rtl/conv_modem_pkg.sv
// Shared constants and encoder helper for the convolutional modem chain.
// Generator taps are ordered {x, s0, s1}.
package conv_modem_pkg;

    localparam int         SPB_DEFAULT = 8;
    localparam logic [2:0] G0          = 3'b111;
    localparam logic [2:0] G1          = 3'b101;
    localparam int         ERR_CNT_W   = 16;

    function automatic logic conv_bit(
        input logic [2:0] g,
        input logic       xb,
        input logic [1:0] s
    );
        return ^(g & {xb, s[0], s[1]});
    endfunction

endpackage

// File: rtl/conv_modem_chain_bit_demod.sv
// Coherent per-bit demodulator: match counter, majority decision, strobe.
// Optional decision error counter under CONV_MODEM_ERR_CNT_EN.
module bit_demod
    import conv_modem_pkg::*;
#(
    parameter int SPB = SPB_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   active,
    input  logic [$clog2(SPB)-1:0] k,
    input  logic                   idx,
    input  logic                   sample,
    input  logic                   ref_bit,
`ifdef CONV_MODEM_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0]   err_cnt,
`endif
    output logic                   dec_bit,
    output logic                   dec_idx,
    output logic                   dec_valid
);

    localparam int KW = $clog2(SPB);
    localparam int CW = $clog2(SPB) + 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] sum;
    logic          first;
    logic          last;
    logic          match;
    logic          decide;

    always_comb begin
        first  = (k == '0);
        last   = (k == KW'(SPB - 1));
        match  = ~(sample ^ k[0]);
        sum    = (first ? '0 : cnt) + CW'(match);
        // An exact tie carries no information and resolves to 0.
        decide = (sum > CW'(SPB / 2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dec_bit   <= 1'b0;
            dec_idx   <= 1'b0;
            dec_valid <= 1'b0;
        end else begin
            cnt       <= active ? sum : '0;
            dec_valid <= active && last;
            if (active && last) begin
                dec_bit <= decide;
                dec_idx <= idx;
            end
        end
    end

`ifdef CONV_MODEM_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (active && last && (decide != ref_bit)
                     && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    logic unused_ref;
    assign unused_ref = ref_bit;
`endif

endmodule

// File: rtl/conv_modem_chain.sv
// Rate-1/2 K=3 convolutional encoder, BPSK-style modulator and demodulator.
// Define CONV_MODEM_ERR_CNT_EN to add the err_cnt decision-error counter.
module conv_modem_chain
    import conv_modem_pkg::*;
#(
    parameter int SPB = SPB_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 x,
    input  logic                 x_valid,
    output logic                 x_ready,
    output logic                 code_bit,
    output logic                 mod_out,
    input  logic                 demod_in,
    output logic                 dec_bit,
    output logic                 dec_idx,
`ifdef CONV_MODEM_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] err_cnt,
`endif
    output logic                 dec_valid
);

    localparam int PAIR = 2 * SPB;
    localparam int PW   = $clog2(PAIR);
    localparam int KW   = $clog2(SPB);

    logic [PW-1:0] p;
    logic [PW-1:0] p_nxt;
    logic [1:0]    s;
    logic          tx_active;
    logic          y0;
    logic          y1;
    logic          accept;
    logic          act_nxt;
    logic          y0_nxt;
    logic          y1_nxt;
    logic          bit_nxt;
    logic          mod_nxt;
    logic          idx;
    logic [KW-1:0] k;

    assign x_ready = (p == PW'(PAIR - 1));
    assign accept  = x_valid && x_ready;

    // mod_out/code_bit are registered, so they are built from next-cycle
    // timer and pair state to land on the clock after the accept edge.
    always_comb begin
        p_nxt   = x_ready ? '0 : p + 1'b1;
        act_nxt = x_ready ? accept : tx_active;
        y0_nxt  = accept ? conv_bit(G0, x, s) : y0;
        y1_nxt  = accept ? conv_bit(G1, x, s) : y1;
        bit_nxt = act_nxt
                & ((p_nxt >= PW'(SPB)) ? y1_nxt : y0_nxt);
        mod_nxt = act_nxt & (p_nxt[0] ^ ~bit_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            s         <= 2'b00;
            tx_active <= 1'b0;
            y0        <= 1'b0;
            y1        <= 1'b0;
            code_bit  <= 1'b0;
            mod_out   <= 1'b0;
        end else begin
            p         <= p_nxt;
            tx_active <= act_nxt;
            y0        <= y0_nxt;
            y1        <= y1_nxt;
            code_bit  <= bit_nxt;
            mod_out   <= mod_nxt;
            if (accept) begin
                s <= {s[0], x};
            end
        end
    end

    // Receive side sees the registered (one-clock-later) timing.
    always_comb begin
        idx = (p >= PW'(SPB));
        k   = idx ? KW'(p - PW'(SPB)) : KW'(p);
    end

    bit_demod #(
        .SPB (SPB)
    ) u_bit_demod (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (tx_active),
        .k         (k),
        .idx       (idx),
        .sample    (demod_in),
        .ref_bit   (code_bit),
`ifdef CONV_MODEM_ERR_CNT_EN
        .err_cnt   (err_cnt),
`endif
        .dec_bit   (dec_bit),
        .dec_idx   (dec_idx),
        .dec_valid (dec_valid)
    );

endmodule

// File: tb/tb_conv_modem_chain.sv
// Directed, table-driven bench for conv_modem_chain in loopback.
// Optional err_cnt checks follow CONV_MODEM_ERR_CNT_EN.
module tb_conv_modem_chain;
    import conv_modem_pkg::*;

    localparam int SPB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic x = 1'b0;
    logic x_valid = 1'b0;
    logic flip = 1'b0;
    logic x_ready;
    logic code_bit;
    logic mod_out;
    logic demod_in;
    logic dec_bit;
    logic dec_idx;
    logic dec_valid;
`ifdef CONV_MODEM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;
`endif

    assign demod_in = mod_out ^ flip;

    always #5 clk = ~clk;

    conv_modem_chain #(
        .SPB (SPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .code_bit  (code_bit),
        .mod_out   (mod_out),
        .demod_in  (demod_in),
        .dec_bit   (dec_bit),
        .dec_idx   (dec_idx),
`ifdef CONV_MODEM_ERR_CNT_EN
        .err_cnt   (err_cnt),
`endif
        .dec_valid (dec_valid)
    );

    typedef struct {
        logic        xv;
        logic        x;
        logic        y0;
        logic        y1;
        logic [15:0] mask;
        logic        d0;
        logic        d1;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   exp_err = 0;
    logic prev_act = 1'b0;
    logic prev_d1 = 1'b0;
    logic prev_y1 = 1'b0;

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_err(input string name);
`ifdef CONV_MODEM_ERR_CNT_EN
        check(name, 16'(err_cnt), 16'(exp_err));
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    // Entered in the clock where x_ready is high; leaves in the next one.
    task automatic run_pair(input vec_t v, input string tag);
        logic bitv;
        logic exp_mod;
        logic exp_dv;
        check({tag, " rdy"}, 16'(x_ready), 16'd1);
        x_valid = v.xv;
        x       = v.x;
        step();
        x_valid = 1'b0;
        x       = 1'b0;
        for (int j = 0; j < 2 * SPB; j++) begin
            flip    = v.mask[j];
            bitv    = v.xv & ((j < SPB) ? v.y0 : v.y1);
            exp_mod = v.xv & (j[0] ^ ~bitv);
            exp_dv  = (j == 0 && prev_act) || (j == SPB && v.xv);
            check($sformatf("%s mod j%0d", tag, j),
                  16'(mod_out), 16'(exp_mod));
            check($sformatf("%s cb j%0d", tag, j),
                  16'(code_bit), 16'(bitv));
            check($sformatf("%s dv j%0d", tag, j),
                  16'(dec_valid), 16'(exp_dv));
            check($sformatf("%s rdy j%0d", tag, j),
                  16'(x_ready), 16'(j == 2 * SPB - 1));
            if (exp_dv) begin
                if (j == 0) begin
                    if (prev_d1 != prev_y1) exp_err++;
                    check({tag, " d1prev"}, 16'(dec_bit), 16'(prev_d1));
                    check({tag, " idx1"}, 16'(dec_idx), 16'd1);
                end else begin
                    if (v.d0 != v.y0) exp_err++;
                    check({tag, " d0"}, 16'(dec_bit), 16'(v.d0));
                    check({tag, " idx0"}, 16'(dec_idx), 16'd0);
                end
                check_err({tag, " err"});
            end
            if (j < 2 * SPB - 1) step();
        end
        prev_act = v.xv;
        prev_d1  = v.d1;
        prev_y1  = v.y1;
    endtask

    task automatic wait_ready(input string tag);
        int c;
        c = 0;
        while (!x_ready && c < 40) begin
            step();
            c++;
        end
        check({tag, " first rdy clk"}, 16'(c), 16'd15);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " mod"}, 16'(mod_out), 16'd0);
        check({tag, " cb"}, 16'(code_bit), 16'd0);
        check({tag, " dv"}, 16'(dec_valid), 16'd0);
        check({tag, " db"}, 16'(dec_bit), 16'd0);
        check({tag, " di"}, 16'(dec_idx), 16'd0);
        check({tag, " rdy"}, 16'(x_ready), 16'd0);
        check_err({tag, " err"});
    endtask

    vec_t tbl[10];
    vec_t v_zero;
    vec_t v_idle;

    initial begin
        //          xv    x     y0    y1    mask      d0    d1
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0F00, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        v_zero = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        v_idle = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

        rst_n = 1'b0;
        repeat (3) step();
        check_idle("rst0");
        rst_n = 1'b1;
        wait_ready("rst0");

        for (int i = 0; i < 10; i++) begin
            run_pair(tbl[i], $sformatf("v%0d", i));
        end

        // Abort a pair mid-flight with an asynchronous reset.
        x_valid = 1'b1;
        x       = 1'b1;
        step();
        x_valid = 1'b0;
        x       = 1'b0;
        repeat (4) step();
        #1;
        rst_n = 1'b0;
        #1;
        exp_err  = 0;
        prev_act = 1'b0;
        check_idle("rst1");
        step();
        step();
        rst_n = 1'b1;
        wait_ready("rst1");
        run_pair(v_zero, "z0");
        run_pair(v_idle, "z1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
